// File: rtl/gnr_drv_pkg.sv
// Shared types and constants for the GRN node run controller.
// STEPS_PER_CYCLE is the number of clock cycles one network step occupies.
package gnr_drv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_S0A    = 3'd3,
      ST_S0B    = 3'd4,
      ST_S1     = 3'd5,
      ST_CHECK  = 3'd6,
      ST_DONE   = 3'd7
   } drv_state_e;

   localparam int STEPS_PER_CYCLE = 4;

endpackage

// File: rtl/gnr_node_driver.sv
// Run controller for a bank of two-slot GRN nodes: loads an initial state,
// steps the network until a step limit, a fixed point or an abort.
module gnr_node_driver
   import gnr_drv_pkg::*;
#(
   parameter int NUM_NODES = 16,
   parameter int STEP_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [NUM_NODES-1:0] cfg_init,
   input  logic [STEP_W-1:0]    cfg_steps,
   input  logic [NUM_NODES-1:0] node_s0,
   input  logic [NUM_NODES-1:0] node_s1,
   output logic                 reset_nos,
   output logic                 start_s0,
   output logic                 start_s1,
   output logic [NUM_NODES-1:0] init_state,
   output logic                 busy,
   output logic                 done,
   output logic                 fixed_point,
   output logic                 aborted,
   output logic [NUM_NODES-1:0] final_s0,
   output logic [NUM_NODES-1:0] final_s1,
   output logic [STEP_W-1:0]    steps_done
);

   drv_state_e state, state_nxt;

   logic [STEP_W-1:0]      steps_lim;
   logic [STEP_W-1:0]      steps_inc;
   logic [2*NUM_NODES-1:0] prev;
   logic [2*NUM_NODES-1:0] cur;
   logic                   is_fixed;
   logic                   lim_hit;

   assign cur       = {node_s0, node_s1};
   assign is_fixed  = (cur == prev);
   assign steps_inc = (&steps_done) ? steps_done : steps_done + STEP_W'(1);
   // An all-ones limit means "no limit": the run ends only on fixed point or stop.
   assign lim_hit   = !(&steps_lim) && (steps_inc == steps_lim);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_SETTLE;
         ST_SETTLE: state_nxt = (steps_lim == '0) ? ST_DONE : ST_S0A;
         ST_S0A:    state_nxt = stop ? ST_DONE : ST_S0B;
         ST_S0B:    state_nxt = stop ? ST_DONE : ST_S1;
         ST_S1:     state_nxt = stop ? ST_DONE : ST_CHECK;
         ST_CHECK: begin
            if (stop || is_fixed || lim_hit) state_nxt = ST_DONE;
            else                             state_nxt = ST_S0A;
         end
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are decoded from state alone so at most one is ever high.
   always_comb begin
      reset_nos = (state == ST_LOAD);
      start_s0  = (state == ST_S0A) || (state == ST_S0B);
      start_s1  = (state == ST_S1);
      busy      = (state != ST_IDLE);
      done      = (state == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_state  <= '0;
         steps_lim   <= '0;
         steps_done  <= '0;
         fixed_point <= 1'b0;
         aborted     <= 1'b0;
         prev        <= '0;
         final_s0    <= '0;
         final_s1    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  init_state  <= cfg_init;
                  steps_lim   <= cfg_steps;
                  steps_done  <= '0;
                  fixed_point <= 1'b0;
                  aborted     <= 1'b0;
               end
            end
            ST_SETTLE: prev <= cur;
            ST_S0A, ST_S0B, ST_S1: begin
               if (stop) aborted <= 1'b1;
            end
            ST_CHECK: begin
               if (stop) begin
                  aborted <= 1'b1;
               end else begin
                  steps_done <= steps_inc;
                  if (is_fixed) fixed_point <= 1'b1;
                  else          prev        <= cur;
               end
            end
            ST_DONE: begin
               final_s0 <= node_s0;
               final_s1 <= node_s1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gnr_node_driver.sv
// Randomized bench for gnr_node_driver against a step-level run model
// and a scripted node array that plays back a prepared state sequence.
module tb_gnr_node_driver;
   import gnr_drv_pkg::*;

   localparam int NN   = 4;
   localparam int SW   = 4;
   localparam int SMAX = (1 << SW) - 1;
   localparam int SEQN = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, stop;
   logic [NN-1:0] cfg_init;
   logic [SW-1:0] cfg_steps;
   logic [NN-1:0] node_s0, node_s1;
   logic          reset_nos, start_s0, start_s1, busy, done, fixed_point, aborted;
   logic [NN-1:0] init_state, final_s0, final_s1;
   logic [SW-1:0] steps_done;

   always #5 clk = ~clk;

   gnr_node_driver #(.NUM_NODES(NN), .STEP_W(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_init(cfg_init), .cfg_steps(cfg_steps),
      .node_s0(node_s0), .node_s1(node_s1),
      .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
      .init_state(init_state), .busy(busy), .done(done),
      .fixed_point(fixed_point), .aborted(aborted),
      .final_s0(final_s0), .final_s1(final_s1), .steps_done(steps_done)
   );

   // State of the network after step k is (seq_s0[k], seq_s1[k]).
   logic [NN-1:0] seq_s0 [SEQN];
   logic [NN-1:0] seq_s1 [SEQN];
   int            n0, n1;
   bit            ph;

   // Two s0 strobes make one s0 update; each s1 strobe makes one s1 update.
   always @(posedge clk) begin
      if (reset_nos) begin
         node_s0 <= init_state;
         node_s1 <= seq_s1[0];
         n0 <= 0; n1 <= 0; ph <= 1'b0;
      end else begin
         if (start_s0) begin
            if (ph && n0 < SEQN-2) begin
               node_s0 <= seq_s0[n0+1];
               n0 <= n0 + 1;
            end
            ph <= ~ph;
         end
         if (start_s1 && n1 < SEQN-2) begin
            node_s1 <= seq_s1[n1+1];
            n1 <= n1 + 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   logic [NN-1:0] h_f0, h_f1, h_init;
   logic          h_fp, h_ab;
   logic [SW-1:0] h_steps;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_idle();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_reset_nos", reset_nos, 0);
      chk("idle_start_s0", start_s0, 0);
      chk("idle_start_s1", start_s1, 0);
      chk("idle_fixed_point", fixed_point, h_fp);
      chk("idle_aborted", aborted, h_ab);
      chk("idle_steps_done", steps_done, h_steps);
      chk("idle_final_s0", final_s0, h_f0);
      chk("idle_final_s1", final_s1, h_f1);
      chk("idle_init_state", init_state, h_init);
   endtask

   // mode 0: both slots toggle every step (never repeats); 1: static; 2: random with repeats
   task automatic build_seq(input logic [NN-1:0] init, input int mode);
      seq_s0[0] = init;
      seq_s1[0] = NN'($urandom);
      for (int k = 1; k < SEQN; k++) begin
         if (mode == 0) begin
            seq_s0[k] = ~seq_s0[k-1];
            seq_s1[k] = ~seq_s1[k-1];
         end else if (mode == 1 || $urandom_range(3) == 0) begin
            seq_s0[k] = seq_s0[k-1];
            seq_s1[k] = seq_s1[k-1];
         end else begin
            seq_s0[k] = NN'($urandom);
            seq_s1[k] = NN'($urandom);
         end
      end
   endtask

   // Step-level outcome: start at cycle 0, step k runs cycles 4k-1..4k+2.
   function automatic void model(input int n, input int stop_c, output int done_c,
                                 output bit fp, output bit ab, output int st);
      done_c = -1; fp = 0; ab = 0; st = 0;
      if (n == 0) begin
         done_c = 3;
         return;
      end
      for (int k = 1; k < SEQN - 2; k++) begin
         for (int c = STEPS_PER_CYCLE*k - 1; c <= STEPS_PER_CYCLE*k + 2; c++)
            if (c == stop_c) begin
               done_c = c + 1; ab = 1;
               return;
            end
         st = (st >= SMAX) ? SMAX : st + 1;
         if (seq_s0[k] == seq_s0[k-1] && seq_s1[k] == seq_s1[k-1]) begin
            fp = 1; done_c = STEPS_PER_CYCLE*k + 3;
            return;
         end
         if (n != SMAX && k == n) begin
            done_c = STEPS_PER_CYCLE*k + 3;
            return;
         end
      end
   endfunction

   // Caller is at posedge+1 of an IDLE cycle; returns at posedge+1 of the
   // cycle after DONE with start already driven for that cycle.
   task automatic run_case(input logic [NN-1:0] init, input int n, input int stop_c,
                           input int mode, input bit hold, input int lit_done,
                           input int lit_steps);
      int  done_c, st, seen, i0, i1, ph4, e_steps;
      bit  fp, ab;
      build_seq(init, mode);
      model(n, stop_c, done_c, fp, ab, st);
      if (done_c < 0) begin
         checks++; errors++;
         $display("FAIL model_bound: run n=%0d did not end within %0d steps", n, SEQN-2);
         return;
      end
      start = 1'b1; stop = 1'b0; cfg_init = init; cfg_steps = SW'(n);
      @(negedge clk);
      check_idle();
      @(posedge clk); #1;
      seen = -1; i0 = 0; i1 = 0;
      for (int c = 1; c <= done_c; c++) begin
         start    = hold ? 1'b1 : 1'($urandom_range(1));
         stop     = (c == stop_c);
         cfg_init = NN'($urandom);
         cfg_steps = SW'($urandom);
         ph4 = (c - 3) % STEPS_PER_CYCLE;
         @(negedge clk);
         if (done && seen < 0) seen = c;
         chk("reset_nos", reset_nos, c == 1);
         chk("start_s0", start_s0, c >= 3 && c < done_c && ph4 < 2);
         chk("start_s1", start_s1, c >= 3 && c < done_c && ph4 == 2);
         chk("busy", busy, 1);
         chk("done", done, c == done_c);
         chk("init_state", init_state, init);
         if (c < done_c) begin
            e_steps = (c >= 3) ? (c - 3) / STEPS_PER_CYCLE : 0;
            if (e_steps > SMAX) e_steps = SMAX;
            chk("run_fixed_point", fixed_point, 0);
            chk("run_aborted", aborted, 0);
            chk("run_steps_done", steps_done, e_steps);
            if (c >= 3 && ph4 == 1) i0++;
            if (c >= 3 && ph4 == 2) i1++;
         end else begin
            chk("done_fixed_point", fixed_point, fp);
            chk("done_aborted", aborted, ab);
            chk("done_steps_done", steps_done, st);
            if (lit_steps >= 0) chk("lit_steps", steps_done, lit_steps);
         end
         @(posedge clk); #1;
      end
      if (lit_done >= 0) chk("lit_done_cycle", seen, lit_done);
      start = hold; stop = 1'b0;
      h_f0 = seq_s0[i0]; h_f1 = seq_s1[i1];
      h_fp = fp; h_ab = ab; h_steps = SW'(st); h_init = init;
   endtask

   task automatic idle_cycle();
      start = 1'b0; stop = 1'($urandom_range(1));
      @(negedge clk);
      check_idle();
      @(posedge clk); #1;
      stop = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_init = '0; cfg_steps = '0;
      h_f0 = '0; h_f1 = '0; h_init = '0; h_fp = 1'b0; h_ab = 1'b0; h_steps = '0;
      for (int k = 0; k < SEQN; k++) begin seq_s0[k] = '0; seq_s1[k] = '0; end
      #1 rst = 1'b0;
      #2 check_idle();
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); check_idle();
      @(posedge clk); #1;

      // toggling nodes, three steps: done in cycle 15
      run_case(4'b1010, 3, -1, 0, 0, 15, 3);
      idle_cycle();
      // static nodes: fixed point on step 1, done in cycle 7
      run_case(4'b0110, 5, -1, 1, 0, 7, 1);
      if (final_s0 !== 4'b0110) begin
         checks++; errors++;
         $display("FAIL static_final_s0: got %0h expected 6", final_s0);
      end else checks++;
      // zero step limit: done in cycle 3, no advance strobes
      run_case(4'b1100, 0, -1, 0, 0, 3, 0);
      idle_cycle();
      // stop in S0B of step 2
      run_case(4'b0011, 5, 8, 0, 0, 9, 1);
      // stop in LOAD/SETTLE ignored
      run_case(4'b1001, 2, 2, 0, 0, 11, 2);
      // stop in CHECK beats the fixed-point decision
      run_case(4'b0101, 4, 6, 1, 0, 7, 0);
      // start held: exactly one run, next accepted the cycle after done
      run_case(4'b1110, 2, -1, 0, 1, 11, 2);
      run_case(4'b0001, 1, -1, 0, 0, 7, 1);
      // unlimited steps, count saturates before the stop
      run_case(4'b1011, SMAX, 81, 0, 0, 82, SMAX);
      idle_cycle();

      // asynchronous reset in cycle 5 of a run
      build_seq(4'b0110, 0);
      start = 1'b1; cfg_init = 4'b0110; cfg_steps = 4'd5;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      #1 rst = 1'b0;
      h_f0 = '0; h_f1 = '0; h_init = '0; h_fp = 1'b0; h_ab = 1'b0; h_steps = '0;
      #1 check_idle();
      @(negedge clk); check_idle();
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); check_idle();
      @(posedge clk); #1;
      idle_cycle();
      run_case(4'b0110, 2, -1, 0, 0, 11, 2);

      for (int r = 0; r < 30; r++) begin
         int sc;
         sc = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(1, 40));
         run_case(NN'($urandom), $urandom_range(0, 8), sc, $urandom_range(0, 2),
                  1'($urandom_range(1)), -1, -1);
         if ($urandom_range(1) == 0) idle_cycle();
      end
      start = 1'b0;
      @(negedge clk); check_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
